// File: rtl/serout_arbiter.sv
// serout_arbiter: round-robin arbiter driving one framed serial output.
// Define SEROUT_PARITY_EN to append an odd-parity slot after the data bits.
module serout_arbiter #(
  parameter int NREQ      = 4,
  parameter int WORD_W    = 26,
  parameter int GAP_SLOTS = 1
) (
  input  logic                    CLK,
  input  logic                    RST,
  input  logic                    BIT_EN,
  input  logic                    ENA,
  input  logic [NREQ-1:0]         REQ,
  input  logic [NREQ*WORD_W-1:0]  DATA,
  output logic [NREQ-1:0]         ACK,
  output logic [$clog2(NREQ)-1:0] GNT_ID,
  output logic                    BUSY,
  output logic                    FRAME,
  output logic                    SDO
);
  localparam int IDW = $clog2(NREQ);
  localparam int CW  = $clog2(WORD_W + 1);
  localparam int GW  = $clog2(GAP_SLOTS + 1);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_DATA = 2'd1,
`ifdef SEROUT_PARITY_EN
    S_PAR  = 2'd3,
`endif
    S_GAP  = 2'd2
  } state_t;

  state_t            state_q, state_d;
  logic [IDW-1:0]    ptr_q, ptr_d;
  logic [WORD_W-1:0] shift_q, shift_d;
  logic [CW-1:0]     bcnt_q, bcnt_d;
  logic [GW-1:0]     gcnt_q, gcnt_d;
  logic [NREQ-1:0]   ack_q, ack_d;
  logic [IDW-1:0]    gnt_q, gnt_d;
  logic              busy_q, busy_d;
  logic              frame_q, frame_d;
  logic              sdo_q, sdo_d;
`ifdef SEROUT_PARITY_EN
  logic              par_q, par_d;
`endif

  logic [WORD_W-1:0] words [NREQ];
  logic              req_any;
  logic [IDW-1:0]    win;
  logic [IDW-1:0]    idx;

  always_comb begin
    for (int i = 0; i < NREQ; i++) begin
      words[i] = DATA[i*WORD_W +: WORD_W];
    end
  end

  // First requester at or after the pointer, wrapping.
  always_comb begin
    req_any = 1'b0;
    win     = '0;
    idx     = '0;
    for (int i = 0; i < NREQ; i++) begin
      idx = IDW'((int'(ptr_q) + i) % NREQ);
      if (!req_any && REQ[idx]) begin
        req_any = 1'b1;
        win     = idx;
      end
    end
  end

  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    shift_d = shift_q;
    bcnt_d  = bcnt_q;
    gcnt_d  = gcnt_q;
    ack_d   = '0;
    gnt_d   = gnt_q;
    busy_d  = busy_q;
    frame_d = frame_q;
    sdo_d   = sdo_q;
`ifdef SEROUT_PARITY_EN
    par_d   = par_q;
`endif
    if (BIT_EN) begin
      case (state_q)
        S_IDLE: begin
          frame_d = 1'b0;
          sdo_d   = 1'b0;
          busy_d  = 1'b0;
          if (ENA && req_any) begin
            shift_d    = words[win];
            ack_d[win] = 1'b1;
            gnt_d      = win;
            busy_d     = 1'b1;
            frame_d    = 1'b1;
            bcnt_d     = CW'(WORD_W);
            ptr_d      = IDW'((int'(win) + 1) % NREQ);
            state_d    = S_DATA;
`ifdef SEROUT_PARITY_EN
            par_d      = ~^words[win];
`endif
          end
        end
        S_DATA: begin
          frame_d = 1'b1;
          sdo_d   = shift_q[WORD_W-1];
          shift_d = shift_q << 1;
          bcnt_d  = bcnt_q - CW'(1);
          if (bcnt_q == CW'(1)) begin
`ifdef SEROUT_PARITY_EN
            state_d = S_PAR;
`else
            state_d = S_GAP;
            gcnt_d  = GW'(GAP_SLOTS);
`endif
          end
        end
`ifdef SEROUT_PARITY_EN
        S_PAR: begin
          frame_d = 1'b1;
          sdo_d   = par_q;
          state_d = S_GAP;
          gcnt_d  = GW'(GAP_SLOTS);
        end
`endif
        S_GAP: begin
          frame_d = 1'b0;
          sdo_d   = 1'b0;
          gcnt_d  = gcnt_q - GW'(1);
          if (gcnt_q == GW'(1)) begin
            busy_d  = 1'b0;
            state_d = S_IDLE;
          end
        end
        default: state_d = S_IDLE;
      endcase
    end
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state_q <= S_IDLE;
      ptr_q   <= '0;
      shift_q <= '0;
      bcnt_q  <= '0;
      gcnt_q  <= '0;
      ack_q   <= '0;
      gnt_q   <= '0;
      busy_q  <= 1'b0;
      frame_q <= 1'b0;
      sdo_q   <= 1'b0;
`ifdef SEROUT_PARITY_EN
      par_q   <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      shift_q <= shift_d;
      bcnt_q  <= bcnt_d;
      gcnt_q  <= gcnt_d;
      ack_q   <= ack_d;
      gnt_q   <= gnt_d;
      busy_q  <= busy_d;
      frame_q <= frame_d;
      sdo_q   <= sdo_d;
`ifdef SEROUT_PARITY_EN
      par_q   <= par_d;
`endif
    end
  end

  assign ACK    = ack_q;
  assign GNT_ID = gnt_q;
  assign BUSY   = busy_q;
  assign FRAME  = frame_q;
  assign SDO    = sdo_q;

endmodule

// File: doc/serout_arbiter.md
Name: serout_arbiter

Overview:
- Shares one serial output channel among NREQ word sources. The channel is a frame strobe plus a serial data bit, clocked per bit-time by a strobe.
- Sits between the LVDC register/telemetry sources and the external serial pins, which are of the PBV/AI3V/WDA kind.
- Arbitrates round-robin, latches the winning 26-bit word, and emits a header slot, then MSB-first data, then a guard gap.
- All timing is counted in BIT_EN slots, not CLK cycles.

Parameters:
- NREQ, 4, number of requesters (2..8).
- WORD_W, 26, data bits per word.
- GAP_SLOTS, 1, bit-times with FRAME low after each word (≥1).

Ports:
- CLK  in  1  system clock.
- RST  in  1  reset; asynchronous, active-high.
- BIT_EN  in  1  one-CLK pulse marking a bit-time; all channel activity advances only on these cycles.
- ENA  in  1  arbitration enable; when low, no new grants are made.
- REQ  in  NREQ  per-requester level request.
- DATA  in  NREQ*WORD_W  per-requester word; slice i is requester i. Must be stable while REQ[i] is high.
- ACK  out  NREQ  one-CLK pulse to the granted requester.
- GNT_ID  out  clog2(NREQ)  index of the current or last granted requester.
- BUSY  out  1  high from the grant until the end of the gap.
- FRAME  out  1  frame strobe; rising edge marks the header slot.
- SDO  out  1  serial data bit.

Behaviour:
- Reset (async, any time, including mid-frame):
  - State IDLE; FRAME=0, SDO=0, ACK=0, BUSY=0, GNT_ID=0.
  - Round-robin pointer set to 0, so requester 0 has highest priority next.
  - Shift register and counters cleared. A word in flight is discarded with no re-ACK.
- Outputs FRAME/SDO are registered. They change only on a CLK edge where BIT_EN=1 and hold between strobes.
- States: IDLE, DATA, GAP (plus PAR with the optional feature).
- IDLE: on BIT_EN with ENA=1 and any REQ high:
  - Grant the first requester at or after the pointer, wrapping modulo NREQ.
  - Latch its DATA slice into the shift register.
  - Pulse ACK[g] for this one cycle; set GNT_ID=g, BUSY=1.
  - Drive the header slot: FRAME=1, SDO=0. Set bit counter = WORD_W.
  - Pointer becomes g+1 mod NREQ. Go to DATA.
  - With no request, ENA=0, or BIT_EN=0: stay in IDLE with outputs 0.
- DATA: each BIT_EN drives SDO = shift MSB, keeps FRAME=1, shifts left, and decrements the counter.
  - After WORD_W strobes (bits WORD_W-1..0 sent), go to GAP, or to PAR if the feature is enabled.
- GAP: each BIT_EN drives FRAME=0, SDO=0. Gap counter runs GAP_SLOTS.
  - On the last gap strobe: BUSY=0, go to IDLE.
  - A new grant is possible on the next BIT_EN.
- Slot timing: header at strobe k, data at k+1..k+WORD_W, gap at k+WORD_W+1..k+WORD_W+GAP_SLOTS. The earliest next header is at k+WORD_W+GAP_SLOTS+1.
- REQ is not sampled outside an IDLE BIT_EN.
  - REQ dropped before its grant: withdrawn, no ACK.
  - REQ held high after ACK: re-requests, and is served again after the others by round-robin.
- ENA falling mid-frame: the current frame and gap complete normally; further grants are blocked.
- BIT_EN held high continuously is legal: one slot per CLK.

Optional Feature:
- Macro SEROUT_PARITY_EN.
- Defined:
  - State PAR is inserted after DATA: one extra slot with FRAME=1, SDO = odd parity of the latched word (~^word).
  - Frame length becomes WORD_W+2 slots before the gap.
- Undefined: no PAR state; frame is exactly header + WORD_W data slots.

Test Plan:
- Reset, then REQ[2]=1, DATA[2]=26'h2AAAAAA, BIT_EN every 8 CLK:
  - ACK[2] pulses once and GNT_ID=2.
  - FRAME high for 27 strobes; SDO = 0 (header) then 1,0,1,0,…,0.
  - FRAME low for 1 strobe; BUSY falls on the gap strobe.
- REQ=4'b1111 held, distinct words 26'h1000001<<i:
  - Grant order 0,1,2,3,0.
  - Headers exactly 28 strobes apart; FRAME low exactly one strobe between frames.
- REQ[1] raised then dropped before an IDLE BIT_EN: no ACK, FRAME stays 0.
- RST asserted at data slot 10 of a frame:
  - FRAME/SDO/BUSY go 0 immediately, without waiting for CLK.
  - After release with REQ=4'b1010, requester 1 is granted (pointer reset to 0).
- ENA dropped at data slot 5 with REQ[0] high:
  - Current word completes; no further ACK while ENA=0.
  - Grant occurs on the first IDLE strobe after ENA=1.
- With SEROUT_PARITY_EN, DATA=26'h0000001:
  - Slot 27 has FRAME=1, SDO=0; the gap follows at slot 28.
  - With DATA=26'h0 the parity slot SDO=1.
